// File: rtl/deframe.sv
// Frame checker + FWFT output buffer for a UART-style SIPO receiver.
// Optional parity checking is enabled by defining DEFRAME_PARITY_CHECK_EN.
module deframe #(
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                          baud_clk,
  input  logic                          reset_n,
  input  logic                          recieved_flag,
  input  logic [10:0]                   data_parll,
  output logic [7:0]                    rx_data,
  output logic                          rx_parity_err,
  output logic                          rx_frame_err,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          overrun_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, CHECK, WRITE, WAIT_LOW} state_e;

  state_e         state_q, state_d;
  logic           flag_q;
  logic [10:0]    frame_q, frame_d;
  logic           parityErr_q, parityErr_d;
  logic           frameErr_q, frameErr_d;
  logic           overrun_q, overrun_d;
  logic [AW-1:0]  wrPtr_q, rdPtr_q;
  logic [CW-1:0]  count_q;
  logic [9:0]     mem_q [FIFO_DEPTH];
  logic [9:0]     headEntry;
  logic           flagRise, full, push, pop, parityCalc;

  assign flagRise = recieved_flag && !flag_q;
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign rx_valid = (count_q != '0);
  assign pop      = rx_valid && rx_ready;

`ifdef DEFRAME_PARITY_CHECK_EN
  assign parityCalc = (^frame_q[9:1]) != 1'(PARITY_ODD);
`else
  logic unused_parity;
  assign unused_parity = frame_q[9] ^ 1'(PARITY_ODD);
  assign parityCalc    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    parityErr_d = parityErr_q;
    frameErr_d  = frameErr_q;
    overrun_d   = 1'b0;
    push        = 1'b0;
    case (state_q)
      IDLE: begin
        if (flagRise) begin
          frame_d = data_parll;
          state_d = CHECK;
        end
      end
      CHECK: begin
        frameErr_d  = (frame_q[0] != 1'b0) || (frame_q[10] != 1'b1);
        parityErr_d = parityCalc;
        state_d     = WRITE;
      end
      WRITE: begin
        // A simultaneous pop frees the slot, so a full buffer still accepts.
        if (!full || pop) push = 1'b1;
        else              overrun_d = 1'b1;
        state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!recieved_flag) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      flag_q      <= 1'b1;
      frame_q     <= 11'h7FF;
      parityErr_q <= 1'b0;
      frameErr_q  <= 1'b0;
      overrun_q   <= 1'b0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      flag_q      <= recieved_flag;
      frame_q     <= frame_d;
      parityErr_q <= parityErr_d;
      frameErr_q  <= frameErr_d;
      overrun_q   <= overrun_d;
      if (push) wrPtr_q <= wrPtr_q + AW'(1);
      if (pop)  rdPtr_q <= rdPtr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge baud_clk) begin
    if (push) mem_q[wrPtr_q] <= {frame_q[8:1], parityErr_q, frameErr_q};
  end

  // Storage is not reset, so the head is masked until an entry exists.
  assign headEntry     = rx_valid ? mem_q[rdPtr_q] : '0;
  assign rx_data       = headEntry[9:2];
  assign rx_parity_err = headEntry[1];
  assign rx_frame_err  = headEntry[0];
  assign overrun_err   = overrun_q;
  assign fifo_count    = count_q;

endmodule

// File: tb/tb_deframe.sv
// Directed self-checking bench for deframe with hand-computed expectations.
module tb_deframe;

`ifdef DEFRAME_PARITY_CHECK_EN
  localparam logic ParChk = 1'b1;
`else
  localparam logic ParChk = 1'b0;
`endif

  logic        baud_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        recieved_flag = 1'b0;
  logic [10:0] data_parll = '0;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_parity_err, rx_frame_err, rx_valid, overrun_err;
  logic [2:0]  fifo_count;

  int   checks = 0;
  int   errors = 0;
  int   overrunCount = 0;
  int   overrunBase;
  logic validEarly;

  deframe #(.FIFO_DEPTH(4), .PARITY_ODD(0)) dut (
    .baud_clk(baud_clk), .reset_n(reset_n), .recieved_flag(recieved_flag),
    .data_parll(data_parll), .rx_data(rx_data), .rx_parity_err(rx_parity_err),
    .rx_frame_err(rx_frame_err), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .overrun_err(overrun_err), .fifo_count(fifo_count)
  );

  always #5 baud_clk = ~baud_clk;

  always @(negedge baud_clk) if (overrun_err) overrunCount++;

  function automatic logic [10:0] mkFrame(input logic [7:0] b);
    return {1'b1, ^b, b, 1'b0};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Holds the flag for 16 cycles; optionally pops during the WRITE cycle.
  task automatic applyStimulus(input logic [10:0] frame, input bit popAtWrite, output logic early);
    @(posedge baud_clk); #1;
    data_parll = frame;
    recieved_flag = 1'b1;
    @(posedge baud_clk); #1;
    @(posedge baud_clk); #1;
    early = rx_valid;
    if (popAtWrite) rx_ready = 1'b1;
    @(posedge baud_clk); #1;
    rx_ready = 1'b0;
    repeat (13) @(posedge baud_clk);
    #1 recieved_flag = 1'b0;
    repeat (2) @(posedge baud_clk);
    #1;
  endtask

  task automatic popAndCheck(input string tag, input logic [7:0] expData, input logic expPar, input logic expFrm);
    checkOutput({tag, "_valid"}, 32'(rx_valid), 32'd1);
    checkOutput({tag, "_data"}, 32'(rx_data), 32'(expData));
    checkOutput({tag, "_par"}, 32'(rx_parity_err), 32'(expPar));
    checkOutput({tag, "_frm"}, 32'(rx_frame_err), 32'(expFrm));
    rx_ready = 1'b1;
    @(posedge baud_clk); #1;
    rx_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge baud_clk);
    #1;
    checkOutput("rst_valid", 32'(rx_valid), 32'd0);
    checkOutput("rst_count", 32'(fifo_count), 32'd0);
    checkOutput("rst_data", 32'(rx_data), 32'd0);
    checkOutput("rst_par", 32'(rx_parity_err), 32'd0);
    checkOutput("rst_frm", 32'(rx_frame_err), 32'd0);
    checkOutput("rst_ovr", 32'(overrun_err), 32'd0);
    reset_n = 1'b1;
    @(posedge baud_clk); #1;

    // Clean 0xA5 frame, latency and single push
    applyStimulus(11'h54A, 1'b0, validEarly);
    checkOutput("a5_early", 32'(validEarly), 32'd0);
    checkOutput("a5_count", 32'(fifo_count), 32'd1);
    popAndCheck("a5", 8'hA5, 1'b0, 1'b0);
    checkOutput("a5_empty", 32'(fifo_count), 32'd0);

    // rx_ready while empty
    rx_ready = 1'b1;
    repeat (3) @(posedge baud_clk);
    #1 rx_ready = 1'b0;
    checkOutput("under_count", 32'(fifo_count), 32'd0);
    checkOutput("under_valid", 32'(rx_valid), 32'd0);

    // Parity bit flipped, stop bit error, start bit error
    applyStimulus(11'h74A, 1'b0, validEarly);
    popAndCheck("par", 8'hA5, ParChk, 1'b0);
    applyStimulus(11'h04A, 1'b0, validEarly);
    popAndCheck("stop", 8'h25, ParChk, 1'b1);
    applyStimulus(11'h54B, 1'b0, validEarly);
    popAndCheck("start", 8'hA5, 1'b0, 1'b1);

    // Overrun on the fifth frame
    overrunBase = overrunCount;
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(mkFrame(8'(i)), 1'b0, validEarly);
      checkOutput("ovr_fill", 32'(fifo_count), (i < 4) ? 32'(i) : 32'd4);
    end
    checkOutput("ovr_pulses", 32'(overrunCount - overrunBase), 32'd1);
    for (int i = 1; i <= 4; i++) popAndCheck("ovr_drain", 8'(i), 1'b0, 1'b0);
    checkOutput("ovr_empty", 32'(fifo_count), 32'd0);

    // Full buffer with a pop during WRITE
    for (int i = 0; i < 4; i++) applyStimulus(mkFrame(8'h11 + 8'(i)), 1'b0, validEarly);
    overrunBase = overrunCount;
    applyStimulus(mkFrame(8'h15), 1'b1, validEarly);
    checkOutput("pp_count", 32'(fifo_count), 32'd4);
    checkOutput("pp_ovr", 32'(overrunCount - overrunBase), 32'd0);
    for (int i = 0; i < 4; i++) popAndCheck("pp_drain", 8'h12 + 8'(i), 1'b0, 1'b0);

    // Reset during CHECK with two entries buffered, flag still high at release
    applyStimulus(mkFrame(8'h21), 1'b0, validEarly);
    applyStimulus(mkFrame(8'h22), 1'b0, validEarly);
    checkOutput("mr_pre", 32'(fifo_count), 32'd2);
    overrunBase = overrunCount;
    @(posedge baud_clk); #1;
    data_parll = mkFrame(8'h23);
    recieved_flag = 1'b1;
    @(posedge baud_clk); #1;
    reset_n = 1'b0;
    repeat (2) @(posedge baud_clk);
    #1 reset_n = 1'b1;
    checkOutput("mr_count", 32'(fifo_count), 32'd0);
    checkOutput("mr_valid", 32'(rx_valid), 32'd0);
    repeat (5) @(posedge baud_clk);
    #1;
    checkOutput("mr_nocap_count", 32'(fifo_count), 32'd0);
    checkOutput("mr_nocap_valid", 32'(rx_valid), 32'd0);
    recieved_flag = 1'b0;
    repeat (2) @(posedge baud_clk);
    #1;
    checkOutput("mr_ovr", 32'(overrunCount - overrunBase), 32'd0);
    applyStimulus(mkFrame(8'h3C), 1'b0, validEarly);
    checkOutput("mr_next_count", 32'(fifo_count), 32'd1);
    popAndCheck("mr_next", 8'h3C, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
